mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 17 +
 rtl/mem_responder_data_ram.sv | 48 ++++
 rtl/mem_responder.sv | 122 ++++++++++++
 tb/tb_mem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared constants for the memory responder and its storage array.
// Holds the FSM state encoding, the default geometry/latency, and the
// width of the BUSY down-counter.
package mem_responder_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 10;  // word-address bits
  localparam int DEFAULT_LATENCY    = 2;   // BUSY cycles per access (1..15)
  localparam int DATA_WIDTH         = 32;
  localparam int CNT_WIDTH          = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_responder_data_ram.sv
// data_ram: single-port word array with synchronous write and synchronous
// read. The read register is the pipeline-visible read data; it only loads
// on a read access, so it holds its value across writes and idle cycles.
//
// Ports:
//   clk      input   clock
//   rst      input   async active-high reset (read register only)
//   en_i     input   access strobe for this cycle
//   we_i     input   1 = write, 0 = read
//   addr_i   input   word address
//   wdata_i  input   write data
//   rdata_o  output  registered read data
module data_ram
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset so it maps onto RAM macros and keeps its
  // contents across a reset of the surrounding logic.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: multi-cycle data-memory responder for a pipelined CPU.
// A valid request in IDLE stalls the pipeline immediately, is latched on the
// next edge, waits LATENCY BUSY cycles, performs the access on the last BUSY
// edge and presents read data in a single DONE cycle. Invalid requests are
// rejected with a one-cycle mem_err pulse and never touch the array.
//
// Ports:
//   clk        input   clock, rising edge
//   rst        input   async active-high reset
//   mem_ren    input   read request
//   mem_wen    input   write request
//   mem_addr   input   byte address
//   mem_dout   input   write data from the pipeline
//   mem_din    output  registered read data to the pipeline
//   mem_stall  output  hold the pipeline while an access is in progress
//   mem_err    output  registered one-cycle reject pulse
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_ren,
  input  logic                  mem_wen,
  input  logic [31:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_stall,
  output logic                  mem_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

  state_e                 state_q;
  logic [CNT_WIDTH-1:0]   cnt_q;
  logic                   we_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   err_q;

  logic req_any;
  logic misaligned;
  logic out_of_range;
  logic req_valid;
  logic req_bad;
  logic ram_en;

  // Request classification. Anything above the word-address field must be
  // zero, otherwise the address aliases outside the array.
  assign req_any      = mem_ren | mem_wen;
  assign misaligned   = |mem_addr[1:0];
  assign out_of_range = |(mem_addr >> (ADDR_WIDTH + 2));
  assign req_valid    = (mem_ren ^ mem_wen) && !misaligned && !out_of_range;
  assign req_bad      = req_any && !req_valid;

  // Stall is raised combinationally in the IDLE detect cycle so the pipeline
  // freezes before the request is latched; DONE releases it.
  assign mem_stall = !rst && (((state_q == ST_IDLE) && req_valid) ||
                              (state_q == ST_BUSY));

  // The access fires on the final BUSY edge; gating with rst keeps an
  // aborted access from reaching the array.
  assign ram_en = !rst && (state_q == ST_BUSY) && (cnt_q == '0);

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            we_q    <= mem_wen;
            addr_q  <= mem_addr[ADDR_WIDTH+1:2];
            wdata_q <= mem_dout;
            cnt_q   <= CNT_LOAD;
            state_q <= ST_BUSY;
          end else if (req_bad) begin
            err_q <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (cnt_q == '0) begin
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_err = err_q;

  data_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_data_ram (
    .clk     (clk),
    .rst     (rst),
    .en_i    (ram_en),
    .we_i    (we_q),
    .addr_i  (addr_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_din)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. Instance 0 uses LATENCY=2, instance 1
// uses LATENCY=1. A reference memory model produces expected read data,
// which is queued when a read is issued and popped in its DONE cycle.
module tb_mem_responder;

  logic        clk;
  logic        rst;
  logic        ren   [2];
  logic        wen   [2];
  logic [31:0] addr  [2];
  logic [31:0] dout  [2];
  logic [31:0] din   [2];
  logic        stall [2];
  logic        err   [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] model [int];
  logic [31:0] sb [$];
  logic [31:0] last_din [2];

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_dut0 (
    .clk(clk), .rst(rst), .mem_ren(ren[0]), .mem_wen(wen[0]),
    .mem_addr(addr[0]), .mem_dout(dout[0]), .mem_din(din[0]),
    .mem_stall(stall[0]), .mem_err(err[0])
  );

  mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_ren(ren[1]), .mem_wen(wen[1]),
    .mem_addr(addr[1]), .mem_dout(dout[1]), .mem_din(din[1]),
    .mem_stall(stall[1]), .mem_err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int key_of(input int idx, input logic [31:0] a);
    return idx * 65536 + int'(a[15:0]);
  endfunction

  task automatic idle_inputs(input int idx);
    ren[idx]  = 1'b0;
    wen[idx]  = 1'b0;
    addr[idx] = 32'h0;
    dout[idx] = 32'h0;
  endtask

  // Issue a valid access, count stall cycles, check DONE-cycle outputs.
  // With chg set, mem_dout is changed once the access is in BUSY.
  task automatic do_access(input int idx, input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic chg, input logic [31:0] d2,
                           input int exp_stall);
    int n;
    bit done;
    @(posedge clk); #1;
    ren[idx] = r; wen[idx] = w; addr[idx] = a; dout[idx] = d;
    if (w) model[key_of(idx, a)] = d;
    if (r) sb.push_back(model[key_of(idx, a)]);
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (stall[idx]) begin
        n++;
        if (chg && n == 2) dout[idx] = d2;
      end else begin
        done = 1'b1;
      end
    end
    check("access_completes", {31'b0, done}, 32'd1);
    check("stall_cycles", 32'(n), 32'(exp_stall));
    check("err_in_done", {31'b0, err[idx]}, 32'd0);
    if (r && sb.size() > 0) last_din[idx] = sb.pop_front();
    check(r ? "din_read" : "din_after_write", din[idx], last_din[idx]);
    idle_inputs(idx);
  endtask

  // Present an invalid request for one IDLE cycle and check the reject.
  task automatic do_invalid(input int idx, input logic r, input logic w,
                            input logic [31:0] a, input string tag);
    @(posedge clk); #1;
    ren[idx] = r; wen[idx] = w; addr[idx] = a; dout[idx] = 32'hBAD0_BAD0;
    @(negedge clk);
    check({tag, "_stall"}, {31'b0, stall[idx]}, 32'd0);
    check({tag, "_err_early"}, {31'b0, err[idx]}, 32'd0);
    @(posedge clk); #1;
    idle_inputs(idx);
    @(negedge clk);
    check({tag, "_err_pulse"}, {31'b0, err[idx]}, 32'd1);
    check({tag, "_stall_after"}, {31'b0, stall[idx]}, 32'd0);
    check({tag, "_din_kept"}, din[idx], last_din[idx]);
    @(negedge clk);
    check({tag, "_err_clear"}, {31'b0, err[idx]}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs(0);
    idle_inputs(1);
    last_din[0] = 32'h0;
    last_din[1] = 32'h0;
    repeat (2) @(negedge clk);
    // Reset state, including a valid request held while in reset.
    ren[0] = 1'b1; addr[0] = 32'h10;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_stall", {31'b0, stall[i]}, 32'd0);
      check("rst_err", {31'b0, err[i]}, 32'd0);
      check("rst_din", din[i], 32'h0);
    end
    idle_inputs(0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write then read, LATENCY=2.
    do_access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0, 3);
    do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 3);

    // Rejected requests.
    do_invalid(0, 1'b1, 1'b0, 32'h13, "misaligned");
    do_invalid(0, 1'b1, 1'b1, 32'h20, "conflict");
    do_invalid(0, 1'b1, 1'b0, 32'h1000, "range");
    // Rejected write must not touch the array: 0x10 still reads back.
    do_invalid(0, 1'b0, 1'b1, 32'h1010, "range_wr");
    do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0, 3);

    // Input change during BUSY is ignored.
    do_access(0, 1'b0, 1'b1, 32'h40, 32'h1111_1111, 1'b1, 32'h2222_2222, 3);
    do_access(0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 32'h0, 3);

    // Reset mid-access.
    do_access(0, 1'b0, 1'b1, 32'h80, 32'h5, 1'b0, 32'h0, 3);
    do_access(0, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0, 3);
    @(posedge clk); #1;
    wen[0] = 1'b1; addr[0] = 32'h80; dout[0] = 32'h9;
    @(negedge clk);
    check("rstmid_detect_stall", {31'b0, stall[0]}, 32'd1);
    @(posedge clk);          // enter first BUSY cycle
    @(posedge clk); #1;      // second BUSY cycle
    rst = 1'b1;
    idle_inputs(0);
    @(negedge clk);
    check("rstmid_stall", {31'b0, stall[0]}, 32'd0);
    check("rstmid_din", din[0], 32'h0);
    check("rstmid_err", {31'b0, err[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_din[0] = 32'h0;
    last_din[1] = 32'h0;
    @(negedge clk);
    check("rstmid_idle_stall", {31'b0, stall[0]}, 32'd0);
    do_access(0, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0, 3);

    // Back-to-back reads, LATENCY=1.
    do_access(1, 1'b0, 1'b1, 32'h0, 32'hA5A5_0000, 1'b0, 32'h0, 2);
    do_access(1, 1'b0, 1'b1, 32'h4, 32'h0000_5A5A, 1'b0, 32'h0, 2);
    @(posedge clk); #1;
    ren[1] = 1'b1; addr[1] = 32'h0;
    sb.push_back(model[key_of(1, 32'h0)]);
    @(negedge clk);
    check("b2b_r0_c0", {31'b0, stall[1]}, 32'd1);
    @(negedge clk);
    check("b2b_r0_c1", {31'b0, stall[1]}, 32'd1);
    @(negedge clk);
    check("b2b_r0_done", {31'b0, stall[1]}, 32'd0);
    if (sb.size() > 0) last_din[1] = sb.pop_front();
    check("b2b_r0_din", din[1], last_din[1]);
    addr[1] = 32'h4;
    sb.push_back(model[key_of(1, 32'h4)]);
    @(negedge clk);
    check("b2b_r1_c0", {31'b0, stall[1]}, 32'd1);
    check("b2b_r1_din_hold", din[1], last_din[1]);
    @(negedge clk);
    check("b2b_r1_c1", {31'b0, stall[1]}, 32'd1);
    @(negedge clk);
    check("b2b_r1_done", {31'b0, stall[1]}, 32'd0);
    if (sb.size() > 0) last_din[1] = sb.pop_front();
    check("b2b_r1_din", din[1], last_din[1]);
    idle_inputs(1);
    @(negedge clk);
    @(negedge clk);
    check("b2b_idle_stall", {31'b0, stall[1]}, 32'd0);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
